// File: rtl/mem_responder.sv
// Wait-state memory responder: one request at a time over valid/ready, serviced
// from an internal word array after WAIT_CYCLES, answered over a second valid/ready.
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // sampled high; the sender holds its payload stable until that edge.

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_accept;
  logic                  w_access;
  logic                  w_a_write;
  logic [ADDR_WIDTH-1:0] w_a_addr;
  logic [DATA_WIDTH-1:0] w_a_wdata;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_err;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign dbg_state = r_state;

  // With no wait states the access happens on the acceptance edge itself,
  // so it must use the live request fields instead of the latched copies.
  always_comb begin
    w_next    = r_state;
    w_access  = 1'b0;
    w_a_write = r_write;
    w_a_addr  = r_addr;
    w_a_wdata = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next    = ST_RESP;
            w_access  = 1'b1;
            w_a_write = req_write;
            w_a_addr  = req_addr;
            w_a_wdata = req_wdata;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_access = 1'b1;
          w_next   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_idx = w_a_addr[DEPTH_LOG2+1:2];
  assign w_err = (w_a_addr[1:0] != 2'b00) ||
                 (w_a_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || w_a_write) ? '0 : r_mem[w_idx];
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_access && w_a_write && !w_err) begin
      r_mem[w_idx] <= w_a_wdata;
    end
  end

  always @(posedge clk) begin
    assert (WAIT_CYCLES >= 0 && WAIT_CYCLES <= 15)
      else $error("mem_responder: WAIT_CYCLES=%0d outside 0..15", WAIT_CYCLES);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed and random requests against an address-rule
// memory model, plus a zero-wait-state instance for back-to-back timing.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          n_checks;
  int          n_errors;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  logic        req_valid_z, req_ready_z, req_write_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic        rsp_valid_z, rsp_ready_z, rsp_err_z, busy_z;
  logic [31:0] rsp_rdata_z;
  logic [1:0]  dbg_state_z;

  logic [31:0] mem_m [0:255];
  logic [31:0] exp_q [$];
  logic        exp_err_q [$];

  mem_responder #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
  );

  mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
    .rsp_err(rsp_err_z), .busy(busy_z), .dbg_state(dbg_state_z)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte address must be word aligned and below 256 words.
  function automatic void model(input logic wr, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic er);
    er = (addr % 4 != 0) || (addr >= 32'd1024);
    rd = 32'h0;
    if (!er) begin
      if (wr) mem_m[addr[9:2]] = wd;
      else    rd = mem_m[addr[9:2]];
    end
  endfunction

  // Driver: one transaction on the WAIT_CYCLES=2 instance, optional back-pressure.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int bp);
    logic [31:0] e_d;
    logic        e_e;
    logic [31:0] got_d;
    logic        got_e;
    int          g;
    int          lat;
    model(wr, addr, wd, e_d, e_e);
    exp_q.push_back(e_d);
    exp_err_q.push_back(e_e);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    rsp_ready = (bp == 0);
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    chk("accept_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("latency_edges", lat + 1, 3);
    got_d = rsp_rdata;
    got_e = rsp_err;
    if (bp > 0) begin
      // A store to word 0 is offered while stalled; it must be ignored.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hBAD0BAD0;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("bp_valid", rsp_valid, 1'b1);
        chk("bp_rdata", rsp_rdata, got_d);
        chk("bp_err", rsp_err, got_e);
        chk("bp_req_ready", req_ready, 1'b0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rsp_rdata", got_d, exp_q.pop_front());
    chk("rsp_err", got_e, exp_err_q.pop_front());
    chk("post_hs_valid", rsp_valid, 1'b0);
    chk("post_hs_busy", busy, 1'b0);
    rsp_ready = 1'b0;
  endtask

  initial begin : main
    logic [31:0] zdat [0:2];
    int          acc_pend [$];
    int          acc_all [$];
    int          idx, nrsp, guard, sel;
    logic [31:0] a;

    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    req_valid_z = 0; req_write_z = 0; req_addr_z = 0; req_wdata_z = 0; rsp_ready_z = 1;
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    rst_n = 1'b1;

    xact(1'b0, 32'h0, 32'h0, 0);
    xact(1'b1, 32'h10, 32'hDEADBEEF, 0);
    xact(1'b0, 32'h10, 32'h0, 0);
    xact(1'b0, 32'h13, 32'h0, 0);
    xact(1'b0, 32'h400, 32'h0, 0);
    xact(1'b1, 32'h400, 32'h55AA55AA, 0);
    xact(1'b0, 32'h0, 32'h0, 0);
    xact(1'b1, 32'h4, 32'hCAFEF00D, 0);
    xact(1'b0, 32'h4, 32'h0, 10);
    xact(1'b0, 32'h0, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = 32'($urandom_range(0, 15)) * 4;
      else if (sel < 8)  a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
      else               a = $urandom;
      xact(1'($urandom), a, $urandom, $urandom_range(0, 3));
    end

    // Zero-wait-state instance: req_valid held, accepts expected every 2 cycles.
    for (int k = 0; k < 3; k++) zdat[k] = $urandom;
    idx = 0; nrsp = 0; guard = 0;
    while (nrsp < 6 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (rsp_valid_z) begin
        if (exp_q.size() > 0 && acc_pend.size() > 0) begin
          chk("z_rdata", rsp_rdata_z, exp_q.pop_front());
          chk("z_err", rsp_err_z, 1'b0);
          chk("z_latency", cyc + 1, acc_pend.pop_front() + 1);
        end else begin
          chk("z_unexpected_rsp", 1'b1, 1'b0);
        end
        nrsp++;
      end
      if (req_ready_z) begin
        if (idx < 6) begin
          req_valid_z = 1'b1;
          req_write_z = (idx < 3);
          req_addr_z  = 32'(idx % 3) * 4;
          req_wdata_z = zdat[idx % 3];
          exp_q.push_back((idx < 3) ? 32'h0 : zdat[idx % 3]);
          acc_pend.push_back(cyc + 1);
          acc_all.push_back(cyc + 1);
          idx++;
        end else begin
          req_valid_z = 1'b0;
        end
      end
    end
    req_valid_z = 1'b0;
    chk("z_responses", nrsp, 6);
    chk("z_accepts", acc_all.size(), 6);
    for (int i = 1; i < acc_all.size(); i++)
      chk("z_interval", acc_all[i] - acc_all[i-1], 2);
    exp_q.delete();

    // Reset during the wait of a store: nothing committed, array cleared.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_err", rsp_err, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 32'h20, 32'h0, 0);
    xact(1'b0, 32'h10, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
